// File: rtl/agc_ctr_pkg.sv
// Shared constants and encodings for the involuntary-counter scheduler.
// Holds cell count, base address, FSM state and increment-op encodings.
package agc_ctr_pkg;

    localparam int          NCTR  = 29;
    localparam logic [5:0]  CBASE = 6'o24;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_PINC = 2'd1,
        OP_MINC = 2'd2
    } op_e;

endpackage

// File: rtl/ctr_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Latency: combinational.
// Backpressure: none, pure function of req.
module ctr_prio_enc #(
    parameter int N = 29
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [4:0]   idx
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = 5'(i);
            end
        end
    end

endmodule

// File: rtl/ctr_prio_sched.sv
// Latches +1/-1 counter requests and grants one counter cycle per offered slot, lowest cell first.
// Latency: request to CTROR 1 edge; SLOT to CGNT/CAD 1 edge; CDONE to idle 1 edge.
// Backpressure: INHINC or an in-progress cycle withholds grants; pending requests are retained.
module ctr_prio_sched #(
    parameter int         NCTR  = agc_ctr_pkg::NCTR,
    parameter logic [5:0] CBASE = agc_ctr_pkg::CBASE
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            GOJAM,
    input  logic [NCTR-1:0] PINC_REQ,
    input  logic [NCTR-1:0] MINC_REQ,
    input  logic            INHINC,
    input  logic            SLOT,
    input  logic            CDONE,
    output logic            CTROR,
    output logic            CGNT,
    output logic            CBUSY,
    output logic [5:0]      CAD,
    output logic            CPLUS,
    output logic            CMINUS
);

    import agc_ctr_pkg::*;

    state_t          state, state_n;
    logic [NCTR-1:0] pp, mp, pend;
    logic [NCTR-1:0] gmask, base_p, base_m, cancel, pp_n, mp_n;
    logic            enc_vld;
    logic [4:0]      enc_idx;
    logic            gnt;
    logic            ctror_q, cgnt_q;
    logic [5:0]      cad_q;
    op_e             op_q;
    logic            kill;

    assign kill = rst | GOJAM;
    assign pend = pp | mp;

    ctr_prio_enc #(.N(NCTR)) u_enc (
        .req (pend),
        .vld (enc_vld),
        .idx (enc_idx)
    );

    assign gnt = (state == S_IDLE) && SLOT && ctror_q && enc_vld && !INHINC;

    always_comb begin
        gmask = '0;
        if (gnt) gmask[enc_idx] = 1'b1;
    end

    // Winner's old bits are dropped before OR-ing in new pulses, so a
    // request arriving in the grant cycle survives; the winner is also
    // exempt from cancellation that cycle.
    assign base_p = (pp & ~gmask) | PINC_REQ;
    assign base_m = (mp & ~gmask) | MINC_REQ;
    assign cancel = base_p & base_m & ~gmask;
    assign pp_n   = base_p & ~cancel;
    assign mp_n   = base_m & ~cancel;

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (gnt)   state_n = S_BUSY;
            S_BUSY:  if (CDONE) state_n = S_IDLE;
            default:            state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (kill) state <= S_IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge CLOCK) begin
        if (kill) begin
            pp      <= '0;
            mp      <= '0;
            ctror_q <= 1'b0;
            cgnt_q  <= 1'b0;
            cad_q   <= '0;
            op_q    <= OP_NONE;
        end else begin
            pp      <= pp_n;
            mp      <= mp_n;
            ctror_q <= |(pp_n | mp_n);
            cgnt_q  <= gnt;
            if (gnt) begin
                cad_q <= CBASE + 6'(enc_idx);
                op_q  <= pp[enc_idx] ? OP_PINC : OP_MINC;
            end else if (state == S_BUSY && CDONE) begin
                cad_q <= '0;
                op_q  <= OP_NONE;
            end
        end
    end

    assign CTROR  = ctror_q;
    assign CGNT   = cgnt_q;
    assign CBUSY  = (state == S_BUSY);
    assign CAD    = cad_q;
    assign CPLUS  = (op_q == OP_PINC);
    assign CMINUS = (op_q == OP_MINC);

endmodule

// File: tb/tb_ctr_prio_sched.sv
// Directed bench for ctr_prio_sched with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_ctr_prio_sched;

    localparam int N = 29;

    logic         CLOCK;
    logic         rst;
    logic         GOJAM;
    logic [N-1:0] PINC_REQ;
    logic [N-1:0] MINC_REQ;
    logic         INHINC;
    logic         SLOT;
    logic         CDONE;
    logic         CTROR;
    logic         CGNT;
    logic         CBUSY;
    logic [5:0]   CAD;
    logic         CPLUS;
    logic         CMINUS;

    int n_chk  = 0;
    int n_pass = 0;

    ctr_prio_sched dut (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .GOJAM    (GOJAM),
        .PINC_REQ (PINC_REQ),
        .MINC_REQ (MINC_REQ),
        .INHINC   (INHINC),
        .SLOT     (SLOT),
        .CDONE    (CDONE),
        .CTROR    (CTROR),
        .CGNT     (CGNT),
        .CBUSY    (CBUSY),
        .CAD      (CAD),
        .CPLUS    (CPLUS),
        .CMINUS   (CMINUS)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic slot_pulse();
        SLOT = 1'b1;
        step();
        SLOT = 1'b0;
    endtask

    task automatic done_pulse();
        CDONE = 1'b1;
        step();
        CDONE = 1'b0;
    endtask

    task automatic preq(input int i);
        PINC_REQ = '0;
        PINC_REQ[i] = 1'b1;
        step();
        PINC_REQ = '0;
    endtask

    initial begin
        rst = 1'b1; GOJAM = 1'b0; PINC_REQ = '0; MINC_REQ = '0;
        INHINC = 1'b0; SLOT = 1'b0; CDONE = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_ctror",  32'(CTROR),  0);
        chk("rst_cgnt",   32'(CGNT),   0);
        chk("rst_cbusy",  32'(CBUSY),  0);
        chk("rst_cad",    32'(CAD),    0);
        chk("rst_cplus",  32'(CPLUS),  0);
        chk("rst_cminus", 32'(CMINUS), 0);

        // Single +1 request on cell 0
        preq(0);
        chk("single_ctror", 32'(CTROR), 1);
        chk("single_nognt", 32'(CGNT),  0);
        slot_pulse();
        chk("single_cgnt",  32'(CGNT),  1);
        chk("single_busy",  32'(CBUSY), 1);
        chk("single_cad",   32'(CAD),   32'o24);
        chk("single_cplus", 32'(CPLUS), 1);
        chk("single_cmin",  32'(CMINUS), 0);
        chk("single_ctror0", 32'(CTROR), 0);
        step();
        chk("single_cgnt_pulse", 32'(CGNT), 0);
        chk("single_cad_hold",   32'(CAD),  32'o24);
        step(); step();
        done_pulse();
        chk("single_done_busy", 32'(CBUSY), 0);
        chk("single_done_cad",  32'(CAD),   0);
        chk("single_done_plus", 32'(CPLUS), 0);

        // CDONE while idle has no effect
        done_pulse();
        chk("idle_done_busy", 32'(CBUSY), 0);

        // Priority: cell 16 (-1) and cell 5 (+1) together
        MINC_REQ[16] = 1'b1; PINC_REQ[5] = 1'b1;
        step();
        MINC_REQ = '0; PINC_REQ = '0;
        chk("prio_ctror", 32'(CTROR), 1);
        slot_pulse();
        chk("prio1_cad",   32'(CAD),    32'o31);
        chk("prio1_plus",  32'(CPLUS),  1);
        chk("prio1_min",   32'(CMINUS), 0);
        chk("prio1_ctror", 32'(CTROR),  1);
        done_pulse();
        slot_pulse();
        chk("prio2_cgnt",  32'(CGNT),   1);
        chk("prio2_cad",   32'(CAD),    32'o44);
        chk("prio2_min",   32'(CMINUS), 1);
        chk("prio2_plus",  32'(CPLUS),  0);
        chk("prio2_ctror", 32'(CTROR),  0);
        done_pulse();

        // Cancellation: +1 then -1 on cell 3
        preq(3);
        chk("cancel_set", 32'(CTROR), 1);
        step();
        MINC_REQ[3] = 1'b1;
        step();
        MINC_REQ = '0;
        chk("cancel_ctror", 32'(CTROR), 0);
        slot_pulse();
        chk("cancel_nognt", 32'(CGNT),  0);
        chk("cancel_idle",  32'(CBUSY), 0);

        // Same-cycle +1 and -1 on one cell cancel immediately
        PINC_REQ[11] = 1'b1; MINC_REQ[11] = 1'b1;
        step();
        PINC_REQ = '0; MINC_REQ = '0;
        chk("samecyc_cancel", 32'(CTROR), 0);

        // Inhibit, then grant, then SLOT while busy
        preq(2);
        INHINC = 1'b1;
        slot_pulse();
        chk("inh_nognt", 32'(CGNT),  0);
        chk("inh_ctror", 32'(CTROR), 1);
        INHINC = 1'b0;
        slot_pulse();
        chk("inh_gnt", 32'(CGNT), 1);
        chk("inh_cad", 32'(CAD),  32'o26);
        preq(4);
        slot_pulse();
        chk("busy_nognt", 32'(CGNT),  0);
        chk("busy_still", 32'(CBUSY), 1);
        chk("busy_cad",   32'(CAD),   32'o26);
        done_pulse();
        slot_pulse();
        chk("after_busy_cad", 32'(CAD), 32'o30);
        done_pulse();

        // Re-request of the winner in its grant cycle
        preq(0);
        SLOT = 1'b1; PINC_REQ[0] = 1'b1;
        step();
        SLOT = 1'b0; PINC_REQ = '0;
        chk("rereq_gnt",   32'(CGNT),  1);
        chk("rereq_cad",   32'(CAD),   32'o24);
        chk("rereq_ctror", 32'(CTROR), 1);
        done_pulse();
        slot_pulse();
        chk("rereq2_gnt",   32'(CGNT),  1);
        chk("rereq2_cad",   32'(CAD),   32'o24);
        chk("rereq2_plus",  32'(CPLUS), 1);
        chk("rereq2_ctror", 32'(CTROR), 0);
        done_pulse();

        // Opposite-sense request for the winner in its grant cycle
        preq(7);
        SLOT = 1'b1; MINC_REQ[7] = 1'b1;
        step();
        SLOT = 1'b0; MINC_REQ = '0;
        chk("opp_cad",   32'(CAD),   32'o33);
        chk("opp_plus",  32'(CPLUS), 1);
        chk("opp_ctror", 32'(CTROR), 1);
        done_pulse();
        slot_pulse();
        chk("opp2_cad", 32'(CAD),    32'o33);
        chk("opp2_min", 32'(CMINUS), 1);
        done_pulse();

        // Highest cell
        preq(28);
        slot_pulse();
        chk("top_cad", 32'(CAD), 32'o60);
        done_pulse();

        // GOJAM mid-cycle with cells 1 and 9 pending
        PINC_REQ[1] = 1'b1; PINC_REQ[9] = 1'b1;
        step();
        PINC_REQ = '0;
        slot_pulse();
        chk("jam_pre_cad",   32'(CAD),   32'o25);
        chk("jam_pre_ctror", 32'(CTROR), 1);
        GOJAM = 1'b1;
        step();
        GOJAM = 1'b0;
        chk("jam_ctror", 32'(CTROR),  0);
        chk("jam_cgnt",  32'(CGNT),   0);
        chk("jam_busy",  32'(CBUSY),  0);
        chk("jam_cad",   32'(CAD),    0);
        chk("jam_plus",  32'(CPLUS),  0);
        chk("jam_min",   32'(CMINUS), 0);
        slot_pulse();
        chk("jam_nognt", 32'(CGNT),  0);
        chk("jam_idle",  32'(CBUSY), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
